// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the data-RAM port arbiter: default bus widths,
//   read-return owner encoding and the cpu_streak width helper.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  // Owner of the read whose data arrives from the RAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_PER  = 2'b10
  } owner_e;

  // Width of a counter that must hold 0..weight, never narrower than 1 bit.
  function automatic int streak_width(input int weight);
    return (weight < 1) ? 1 : $clog2(weight + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-port data RAM between the CPU load/store path and the
//   peripheral port. One access is issued per cycle; grant and RAM command
//   are combinational in the same cycle, read data (1-cycle RAM latency) is
//   steered back to whichever requester issued the read.
//
// Ports
//   clock, reset                 system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        CPU request, held until cpu_gnt
//   cpu_gnt                      CPU access issued this cycle
//   cpu_rdata/cpu_rvalid         CPU read return, cycle after the grant
//   p_req/we/addr/wdata          peripheral request, held until p_gnt
//   p_gnt                        peripheral access issued this cycle
//   p_rdata/p_rvalid             peripheral read return, cycle after the grant
//   mem_en/we/addr/wdata         RAM command port
//   mem_rdata                    RAM registered read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int CPU_WEIGHT = 2
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_gnt,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              STREAK_W = streak_width(CPU_WEIGHT);
  localparam logic [STREAK_W-1:0] WEIGHT = STREAK_W'(CPU_WEIGHT);

  logic [STREAK_W-1:0] r_cpu_streak;
  owner_e              r_rd_owner;

  logic w_cpu_pick;
  logic w_per_pick;

  // Grant selection. Reset forces both grants low so no RAM access is
  // issued while reset is held.
  always_comb begin
    w_cpu_pick = 1'b0;
    w_per_pick = 1'b0;
    if (!reset) begin
      if (cpu_req && (!p_req || (r_cpu_streak < WEIGHT))) begin
        w_cpu_pick = 1'b1;
      end else if (p_req) begin
        w_per_pick = 1'b1;
      end
    end
  end

  assign cpu_gnt = w_cpu_pick;
  assign p_gnt   = w_per_pick;

  // RAM command mux; all fields zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_pick) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_per_pick) begin
      mem_en    = 1'b1;
      mem_we    = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpu_streak <= '0;
      r_rd_owner   <= OWN_NONE;
    end else begin
      if (w_cpu_pick && !cpu_we) begin
        r_rd_owner <= OWN_CPU;
      end else if (w_per_pick && !p_we) begin
        r_rd_owner <= OWN_PER;
      end else begin
        r_rd_owner <= OWN_NONE;
      end

      // Streak counts CPU wins only while the peripheral is waiting.
      if (w_cpu_pick && p_req) begin
        if (r_cpu_streak != WEIGHT) begin
          r_cpu_streak <= r_cpu_streak + STREAK_W'(1);
        end
      end else if (w_per_pick || !p_req) begin
        r_cpu_streak <= '0;
      end
    end
  end

  // Gating by reset suppresses the return of a read granted just before
  // reset was raised; the owner register itself clears at the next edge.
  assign cpu_rvalid = !reset && (r_rd_owner == OWN_CPU);
  assign p_rvalid   = !reset && (r_rd_owner == OWN_PER);
  assign cpu_rdata  = mem_rdata;
  assign p_rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, p_req, p_we;
  logic [15:0] cpu_addr, cpu_wdata, p_addr, p_wdata;
  logic        cpu_gnt, cpu_rvalid, p_gnt, p_rvalid;
  logic [15:0] cpu_rdata, p_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .CPU_WEIGHT(2)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .p_req     (p_req),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_gnt     (p_gnt),
    .p_rdata   (p_rdata),
    .p_rvalid  (p_rvalid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [15:0] init_val(input int unsigned a);
    return (a == 32'h10) ? 16'hBEEF : (16'hA000 ^ 16'(a));
  endfunction

  // RAM environment: registered read, 256 words, filled on the first edge.
  logic [15:0] ram [256];
  bit          ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int unsigned i = 0; i < 256; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [15:0] caddr, cwd;
    logic        preq, pwe;
    logic [15:0] paddr, pwd;
    logic        egc, egp;
  } vec_t;

  typedef struct {
    bit          own_cpu;
    logic [15:0] data;
    int          due;
  } rd_t;

  vec_t        tbl[$];
  rd_t         sb[$];
  logic [15:0] model [256];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  function automatic vec_t mk(input logic creq, cwe, input logic [15:0] caddr, cwd,
                              input logic preq, pwe, input logic [15:0] paddr, pwd,
                              input logic egc, egp);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.preq = preq; v.pwe = pwe; v.paddr = paddr; v.pwd = pwd;
    v.egc  = egc;  v.egp = egp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    p_req   = v.preq; p_we   = v.pwe; p_addr   = v.paddr; p_wdata   = v.pwd;
  endtask

  task automatic check_rv();
    rd_t r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk("rvalid", {cpu_rvalid, p_rvalid}, {r.own_cpu, !r.own_cpu});
      chk("rdata", r.own_cpu ? cpu_rdata : p_rdata, r.data);
    end else begin
      chk("rvalid_idle", {cpu_rvalid, p_rvalid}, 2'b00);
    end
  endtask

  // One cycle: drive, check grant/RAM command mid-cycle, then check returns.
  task automatic apply(input vec_t v);
    logic        ewe;
    logic [15:0] ea, ed;
    drive(v);
    @(negedge clk);
    chk("gnt", {cpu_gnt, p_gnt}, {v.egc, v.egp});
    ewe = v.egc ? v.cwe   : (v.egp ? v.pwe   : 1'b0);
    ea  = v.egc ? v.caddr : (v.egp ? v.paddr : 16'h0);
    ed  = v.egc ? v.cwd   : (v.egp ? v.pwd   : 16'h0);
    chk("mem_cmd", {mem_en, mem_we, mem_addr, mem_wdata}, {v.egc | v.egp, ewe, ea, ed});
    if (v.egc) begin
      if (v.cwe) model[v.caddr[7:0]] = v.cwd;
      else       sb.push_back('{1'b1, model[v.caddr[7:0]], cyc + 1});
    end else if (v.egp) begin
      if (v.pwe) model[v.paddr[7:0]] = v.pwd;
      else       sb.push_back('{1'b0, model[v.paddr[7:0]], cyc + 1});
    end
    @(posedge clk); #1;
    cyc++;
    check_rv();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) model[i] = init_val(i);

    // Reset held with both requesters active: nothing issued or returned.
    reset = 1'b1;
    drive(mk(1,0,16'h0010,0, 1,0,16'h0050,0, 0,0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {cpu_gnt, p_gnt}, 2'b00);
      chk("rst_mem", {mem_en, mem_we}, 2'b00);
      @(posedge clk); #1;
      cyc++;
      chk("rst_rvalid", {cpu_rvalid, p_rvalid}, 2'b00);
    end
    reset = 1'b0;
    apply(mk(1,0,16'h0010,0, 1,0,16'h0050,0, 1,0));   // CPU first after reset

    //              creq we caddr    cwd      preq we paddr    pwd      gc gp
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0)); // idle, streak clears
    tbl.push_back(mk(1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 1,0)); // CPU read BEEF
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,1,16'h0020,16'h1234, 0,1)); // per write
    tbl.push_back(mk(1,0,16'h0020,16'h0000, 0,0,16'h0000,16'h0000, 1,0)); // CPU reads it back
    tbl.push_back(mk(1,0,16'h0040,16'h0000, 1,0,16'h0050,16'h0000, 1,0)); // contention
    tbl.push_back(mk(1,0,16'h0040,16'h0000, 1,0,16'h0050,16'h0000, 1,0));
    tbl.push_back(mk(1,0,16'h0040,16'h0000, 1,0,16'h0050,16'h0000, 0,1));
    tbl.push_back(mk(1,0,16'h0040,16'h0000, 1,0,16'h0050,16'h0000, 1,0));
    tbl.push_back(mk(1,0,16'h0040,16'h0000, 1,0,16'h0050,16'h0000, 1,0));
    tbl.push_back(mk(1,0,16'h0040,16'h0000, 1,0,16'h0050,16'h0000, 0,1));
    tbl.push_back(mk(1,0,16'h0060,16'h0000, 0,0,16'h0000,16'h0000, 1,0)); // alternating reads
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,0,16'h0061,16'h0000, 0,1));
    tbl.push_back(mk(1,0,16'h0062,16'h0000, 0,0,16'h0000,16'h0000, 1,0));
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,0,16'h0063,16'h0000, 0,1));
    tbl.push_back(mk(1,1,16'h0070,16'h5555, 0,0,16'h0000,16'h0000, 1,0)); // CPU write
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 1,0,16'h0070,16'h0000, 0,1)); // per reads it
    tbl.push_back(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0));
    foreach (tbl[i]) apply(tbl[i]);

    // Read granted, then reset: its return must be suppressed and the
    // streak (1 -> 2 at the killed read) must be cleared.
    apply(mk(1,0,16'h0041,16'h0000, 1,0,16'h0051,16'h0000, 1,0));
    drive(mk(1,0,16'h0010,16'h0000, 1,0,16'h0051,16'h0000, 1,0));
    @(negedge clk);
    chk("pre_rst_gnt", {cpu_gnt, p_gnt}, 2'b10);
    reset = 1'b1;
    @(posedge clk); #1;
    cyc++;
    chk("rst_kill_rvalid", {cpu_rvalid, p_rvalid}, 2'b00);
    @(negedge clk);
    chk("rst2_gnt", {cpu_gnt, p_gnt, mem_en}, 3'b000);
    @(posedge clk); #1;
    cyc++;
    chk("rst2_rvalid", {cpu_rvalid, p_rvalid}, 2'b00);
    reset = 1'b0;
    apply(mk(1,0,16'h0042,16'h0000, 1,0,16'h0052,16'h0000, 1,0));
    apply(mk(1,0,16'h0042,16'h0000, 1,0,16'h0052,16'h0000, 1,0));
    apply(mk(1,0,16'h0042,16'h0000, 1,0,16'h0052,16'h0000, 0,1));
    apply(mk(0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0,0));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
